// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR front end: sample/tap widths and
// the window-stage state encoding.
package fir_pkg;

    localparam int NTAPS  = 37;
    localparam int DWIDTH = 14;
    localparam int TWIDTH = DWIDTH + 1;
    localparam int CWIDTH = 11;

    typedef logic signed [TWIDTH-1:0] fir_tap_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } win_state_e;

endpackage

// File: rtl/fir_tap_window_if.sv
// Sample handshake plus the parallel tap window presented to the filter.
interface fir_tap_window_if #(
    parameter int DWIDTH = fir_pkg::DWIDTH,
    parameter int NTAPS  = fir_pkg::NTAPS
);
    logic                     EN;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DWIDTH-1:0] s_data;
    logic                     flush;
    logic signed [DWIDTH:0]   taps [NTAPS];
    logic                     t_valid;
    logic                     busy;

    modport master (
        output EN, s_valid, s_data, flush,
        input  s_ready, taps, t_valid, busy
    );

    modport slave (
        input  EN, s_valid, s_data, flush,
        output s_ready, taps, t_valid, busy
    );
endinterface

// File: rtl/fir_shift_reg.sv
// NTAPS-deep delay line; slot 0 takes din on shift, clear zeroes every slot.
module fir_shift_reg #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 37
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] taps [DEPTH]
);

    logic signed [WIDTH-1:0] taps_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n || clear) begin
                        taps_q[gi] <= '0;
                    end else if (shift) begin
                        taps_q[gi] <= din;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (!rst_n || clear) begin
                        taps_q[gi] <= '0;
                    end else if (shift) begin
                        taps_q[gi] <= taps_q[gi-1];
                    end
                end
            end
            assign taps[gi] = taps_q[gi];
        end
    endgenerate

endmodule

// File: rtl/fir_tap_window.sv
// Window stage ahead of the symmetric FIR: warm-up, decimated strobes and
// zero-stuffing flush so the filter only ever sees complete windows.
module fir_tap_window #(
    parameter int DWIDTH = fir_pkg::DWIDTH,
    parameter int NTAPS  = fir_pkg::NTAPS,
    parameter int DECIM  = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    fir_tap_window_if.slave   bus
);
    import fir_pkg::*;

    localparam int FW = $clog2(NTAPS + 1);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    win_state_e             state_q, state_d;
    logic [FW-1:0]          fill_cnt_q, fill_cnt_d;
    logic [FW-1:0]          flush_cnt_q, flush_cnt_d;
    logic [DW-1:0]          dec_cnt_q, dec_cnt_d;
    logic                   t_valid_q, t_valid_d;
    logic                   accept, shift, clear, dec_wrap;
    logic [DW-1:0]          dec_inc;
    logic [FW-1:0]          fill_inc;
    logic signed [DWIDTH:0] din;
    logic signed [DWIDTH:0] taps_w [NTAPS];

    assign bus.s_ready = bus.EN && (state_q != FLUSH) && !bus.flush;
    assign accept      = bus.s_valid && bus.s_ready;
    assign dec_wrap    = (dec_cnt_q == DW'(DECIM - 1));
    assign dec_inc     = dec_wrap ? '0 : dec_cnt_q + 1'b1;
    assign fill_inc    = fill_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        flush_cnt_d = flush_cnt_q;
        dec_cnt_d   = dec_cnt_q;
        t_valid_d   = 1'b0;
        shift       = 1'b0;
        clear       = 1'b0;
        din         = {bus.s_data[DWIDTH-1], bus.s_data};
        case (state_q)
            IDLE, FILL: begin
                if (state_q == FILL && bus.EN && bus.flush) begin
                    clear      = 1'b1;
                    state_d    = IDLE;
                    fill_cnt_d = '0;
                end else if (accept) begin
                    shift      = 1'b1;
                    fill_cnt_d = fill_inc;
                    if (fill_inc == FW'(NTAPS)) begin
                        state_d   = RUN;
                        dec_cnt_d = '0;
                        t_valid_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            RUN: begin
                if (bus.EN && bus.flush) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (accept) begin
                    shift     = 1'b1;
                    dec_cnt_d = dec_inc;
                    t_valid_d = dec_wrap;
                end
            end
            FLUSH: begin
                // Zero shifts count as accepts for decimation; EN low pauses the drain.
                if (bus.EN) begin
                    shift       = 1'b1;
                    din         = '0;
                    dec_cnt_d   = dec_inc;
                    t_valid_d   = dec_wrap;
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_q == FW'(NTAPS - 1)) begin
                        state_d     = IDLE;
                        fill_cnt_d  = '0;
                        dec_cnt_d   = '0;
                        flush_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            flush_cnt_q <= '0;
            dec_cnt_q   <= '0;
            t_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            t_valid_q   <= t_valid_d;
        end
    end

    fir_shift_reg #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (NTAPS)
    ) u_shift_reg (
        .clk   (CLK),
        .rst_n (RST_N),
        .shift (shift),
        .clear (clear),
        .din   (din),
        .taps  (taps_w)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_out
            assign bus.taps[gi] = taps_w[gi];
        end
    endgenerate

    assign bus.t_valid = t_valid_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fir_tap_window.sv
// Directed checks of the window stage with DECIM=1 and DECIM=4 instances
// driven by the same stimulus.
module tb_fir_tap_window;

    logic CLK = 1'b0;
    logic RST_N;
    logic en, sv, fl;
    logic signed [13:0] sd;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fir_tap_window_if #(.DWIDTH(14), .NTAPS(37)) if1 ();
    fir_tap_window_if #(.DWIDTH(14), .NTAPS(37)) if4 ();

    assign if1.EN = en;  assign if1.s_valid = sv;  assign if1.s_data = sd;  assign if1.flush = fl;
    assign if4.EN = en;  assign if4.s_valid = sv;  assign if4.s_data = sd;  assign if4.flush = fl;

    fir_tap_window #(.DWIDTH(14), .NTAPS(37), .DECIM(1)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(if1));
    fir_tap_window #(.DWIDTH(14), .NTAPS(37), .DECIM(4)) dut4 (.CLK(CLK), .RST_N(RST_N), .bus(if4));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; en = 1'b1; sv = 1'b0; fl = 1'b0; sd = '0;
        step(); step();
        RST_N = 1'b1;
    endtask

    task automatic feed(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            sv = 1'b1; sd = 14'(base + k);
            step();
        end
        sv = 1'b0;
    endtask

    task automatic test_reset();
        int nz;
        RST_N = 1'b0; en = 1'b1; sv = 1'b0; fl = 1'b0; sd = '0;
        step(); step();
        nz = 0;
        for (int i = 0; i < 37; i++) if (if1.taps[i] !== 15'd0) nz++;
        checks++;
        if (nz != 0) begin errors++; $display("FAIL reset_taps nonzero=%0d want 0", nz); end
        checks++;
        if (if1.t_valid !== 1'b0 || if1.busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags t_valid=%b busy=%b want 0 0", if1.t_valid, if1.busy);
        end
        RST_N = 1'b1; en = 1'b0;
        #1;
        checks++;
        if (if1.s_ready !== 1'b0) begin errors++; $display("FAIL ready_en_low got %b want 0", if1.s_ready); end
        en = 1'b1;
        #1;
        checks++;
        if (if1.s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", if1.s_ready); end
        $display("test_reset done");
    endtask

    task automatic test_fill_and_decim();
        int early, run_strobes, stall;
        logic [63:0] mask4, want4;
        do_reset();
        early = 0; run_strobes = 0; stall = 0; mask4 = '0;
        for (int k = 1; k <= 49; k++) begin
            sv = 1'b1; sd = 14'(k);
            #1;
            if (!if1.s_ready) stall++;
            step();
            if (k < 37 && if1.t_valid) early++;
            if (k > 37 && if1.t_valid) run_strobes++;
            if (if4.t_valid) mask4[k] = 1'b1;
            if (k == 37) begin
                checks++;
                if (if1.t_valid !== 1'b1 || if1.taps[0] !== 15'd37 || if1.taps[36] !== 15'd1) begin
                    errors++;
                    $display("FAIL first_window t_valid=%b taps0=%0d taps36=%0d want 1 37 1",
                             if1.t_valid, if1.taps[0], if1.taps[36]);
                end
            end
            if (k == 38) begin
                checks++;
                if (if1.t_valid !== 1'b1 || if1.taps[0] !== 15'd38 || if1.taps[36] !== 15'd2) begin
                    errors++;
                    $display("FAIL second_window t_valid=%b taps0=%0d taps36=%0d want 1 38 2",
                             if1.t_valid, if1.taps[0], if1.taps[36]);
                end
            end
        end
        sv = 1'b0;
        checks++;
        if (early != 0) begin errors++; $display("FAIL warmup_strobes got %0d want 0", early); end
        checks++;
        if (run_strobes != 12) begin errors++; $display("FAIL decim1_strobes got %0d want 12", run_strobes); end
        checks++;
        if (stall != 0) begin errors++; $display("FAIL back_to_back stalls=%0d want 0", stall); end
        want4 = (64'd1 << 37) | (64'd1 << 41) | (64'd1 << 45) | (64'd1 << 49);
        checks++;
        if (mask4 !== want4) begin errors++; $display("FAIL decim4_pattern got %h want %h", mask4, want4); end
        step();
        checks++;
        if (if1.t_valid !== 1'b0) begin errors++; $display("FAIL strobe_width got %b want 0", if1.t_valid); end
        $display("test_fill_and_decim done");
    endtask

    task automatic test_sign_ext();
        sv = 1'b1; sd = 14'h2000;
        step();
        sv = 1'b0;
        checks++;
        if (if1.taps[0] !== 15'h6000 || if1.taps[1] !== 15'd49) begin
            errors++;
            $display("FAIL sign_ext taps0=%h taps1=%0d want 6000 49", if1.taps[0], if1.taps[1]);
        end
        $display("test_sign_ext done");
    endtask

    task automatic test_flush_run();
        int low, strobes, nz;
        do_reset();
        feed(40, 1);
        fl = 1'b1; sv = 1'b1; sd = 14'd77;
        step();
        fl = 1'b0; sv = 1'b0;
        checks++;
        if (if1.t_valid !== 1'b0 || if1.busy !== 1'b1 || if1.taps[0] !== 15'd40) begin
            errors++;
            $display("FAIL flush_entry t_valid=%b busy=%b taps0=%0d want 0 1 40", if1.t_valid, if1.busy, if1.taps[0]);
        end
        low = 0; strobes = 0;
        while (!if1.s_ready && low < 100) begin
            low++;
            step();
            if (if1.t_valid) strobes++;
        end
        checks++;
        if (low != 37) begin errors++; $display("FAIL flush_ready_low got %0d want 37", low); end
        checks++;
        if (strobes != 37) begin errors++; $display("FAIL flush_strobes got %0d want 37", strobes); end
        nz = 0;
        for (int i = 0; i < 37; i++) if (if1.taps[i] !== 15'd0) nz++;
        checks++;
        if (nz != 0 || if1.busy !== 1'b0) begin
            errors++; $display("FAIL flush_final nonzero=%0d busy=%b want 0 0", nz, if1.busy);
        end
        $display("test_flush_run done");
    endtask

    task automatic test_flush_fill();
        int nz, early;
        do_reset();
        feed(10, 1);
        fl = 1'b1; sv = 1'b1; sd = 14'd99;
        #1;
        checks++;
        if (if1.s_ready !== 1'b0) begin errors++; $display("FAIL flush_fill_ready got %b want 0", if1.s_ready); end
        step();
        fl = 1'b0; sv = 1'b0;
        nz = 0;
        for (int i = 0; i < 37; i++) if (if1.taps[i] !== 15'd0) nz++;
        checks++;
        if (nz != 0 || if1.busy !== 1'b0 || if1.t_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill_clear nonzero=%0d busy=%b t_valid=%b want 0 0 0", nz, if1.busy, if1.t_valid);
        end
        early = 0;
        for (int k = 1; k <= 37; k++) begin
            sv = 1'b1; sd = 14'(k);
            step();
            if (k < 37 && if1.t_valid) early++;
        end
        sv = 1'b0;
        checks++;
        if (early != 0 || if1.t_valid !== 1'b1 || if1.taps[36] !== 15'd1) begin
            errors++;
            $display("FAIL refill early=%0d t_valid=%b taps36=%0d want 0 1 1", early, if1.t_valid, if1.taps[36]);
        end
        $display("test_flush_fill done");
    endtask

    task automatic test_en_flush();
        int cyc;
        do_reset();
        feed(40, 1);
        fl = 1'b1; step(); fl = 1'b0;
        cyc = 0;
        while (if1.busy && cyc < 200) begin
            en = (cyc >= 10 && cyc < 15) ? 1'b0 : 1'b1;
            step();
            cyc++;
        end
        en = 1'b1;
        checks++;
        if (cyc != 42) begin errors++; $display("FAIL en_pause_flush cycles=%0d want 42", cyc); end
        $display("test_en_flush done");
    endtask

    task automatic test_reset_mid_run();
        int nz;
        do_reset();
        feed(40, 1);
        RST_N = 1'b0; sv = 1'b1; sd = 14'd5;
        step();
        nz = 0;
        for (int i = 0; i < 37; i++) if (if1.taps[i] !== 15'd0) nz++;
        checks++;
        if (nz != 0 || if1.busy !== 1'b0 || if1.t_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run nonzero=%0d busy=%b t_valid=%b want 0 0 0", nz, if1.busy, if1.t_valid);
        end
        RST_N = 1'b1; sv = 1'b0;
        #1;
        checks++;
        if (if1.s_ready !== 1'b1) begin errors++; $display("FAIL ready_post_reset got %b want 1", if1.s_ready); end
        $display("test_reset_mid_run done");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_and_decim();
        test_sign_ext();
        test_flush_run();
        test_flush_fill();
        test_en_flush();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_tap_window.md
# fir_tap_window

Sample window stage directly upstream of the 37-tap symmetric `fir` datapath. It accepts a serial stream of signed 14-bit ADC samples over a valid/ready handshake and maintains a 37-deep delay line. It presents the line as a parallel array of sign-extended 15-bit taps, with a `t_valid` strobe that qualifies the combinational `fir` output. Warm-up, output decimation and end-of-burst flush are handled here, so the filter sees only complete windows.

## Interface
- `DWIDTH`, 14 — input sample width, signed.
- `NTAPS`, 37 — window depth; must match the filter tap count.
- `DECIM`, 1 — output decimation factor, legal range 1..16.
- `CLK` in 1 — system clock, all logic on rising edge.
- `RST_N` in 1 — reset, synchronous, active-low.
- `EN` in 1 — block enable. When low, all state holds and `s_ready` is 0.
- `s_valid` in 1 — input sample valid.
- `s_ready` out 1 — block can accept a sample this cycle.
- `s_data` in DWIDTH — signed input sample.
- `flush` in 1 — single-cycle request to drain or clear the window.
- `taps` out [NTAPS] x (DWIDTH+1) — signed window. `taps[0]` is the newest sample, `taps[NTAPS-1]` the oldest.
- `t_valid` out 1 — one-cycle strobe: `taps` holds a window to be filtered.
- `busy` out 1 — high in FILL, RUN or FLUSH.

## Operation
- **Accept rule.** accept = `s_valid` & `s_ready`.
  - `s_ready` = `EN` & (state ≠ FLUSH) & !`flush`. It is combinational from registered state and the `flush` input only.
- **Shift on accept.** `taps[0]` ← sign-extend(`s_data`); `taps[i]` ← `taps[i-1]`.
- **FSM states:** IDLE, FILL, RUN, FLUSH. Reset state is IDLE.
  - IDLE → FILL on the first accept. `fill_cnt` = 1.
  - FILL: each accept increments `fill_cnt`. The accept that brings `fill_cnt` to NTAPS moves the FSM to RUN and fires `t_valid`. `dec_cnt` is cleared to 0 on that transition.
  - RUN: each accept advances `dec_cnt` modulo DECIM. `t_valid` fires on the accept where `dec_cnt` wraps to 0 (every DECIM-th accept after the first window).
  - `flush` in RUN → FLUSH. One zero per enabled cycle is shifted into `taps[0]`, for NTAPS cycles; the `t_valid` rule continues unchanged, counting each zero shift as an accept. After the NTAPS-th zero the FSM goes to IDLE, with `fill_cnt` = 0 and `dec_cnt` = 0.
  - `flush` in FILL: all taps cleared to 0 in one cycle and the FSM goes to IDLE. A partial window never produces `t_valid`.
  - `flush` in IDLE or FLUSH, or while `EN` = 0: ignored.
- **Simultaneous flush and sample.** If `flush` and `s_valid` arrive together, flush wins and the sample is not accepted (`s_ready` is already 0).
- **EN low mid-FLUSH.** The flush count pauses and resumes when `EN` returns.
- **Counter widths.** `fill_cnt` is $clog2(NTAPS+1) bits. `dec_cnt` is max(1, $clog2(DECIM)) bits. Neither counter wraps outside the rules above.
- **Arithmetic.** Sign extension only (DWIDTH → DWIDTH+1). The extra bit is headroom for the filter's symmetric pre-add. No rounding or saturation.

## Timing
- **Reset values.** `taps` all 0, `t_valid` 0, `busy` 0, state IDLE, counters 0. `s_ready` = `EN` once reset is released.
- **Latency.** 1 cycle. A sample accepted at edge k appears in `taps[0]` after edge k+1. Its qualifying `t_valid` is high in the same cycle `taps` updates.
- **Strobe width.** `t_valid` is high for exactly one cycle per window. The `fir` output is sampled by the consumer in that cycle.
- **Back-to-back accepts.** One sample per cycle sustained; no bubbles are inserted by the block.
- **Reset mid-operation.** `RST_N` low at any edge returns every register to its reset value at that edge, in any state, regardless of `EN`.

## Structure
- **Package `fir_pkg`:**
  - localparams: NTAPS = 37, DWIDTH = 14, TWIDTH = DWIDTH+1, CWIDTH = 11.
  - `fir_tap_t` (signed [TWIDTH-1:0]).
  - `win_state_e` enum {IDLE, FILL, RUN, FLUSH}.
- **Sub-module `fir_shift_reg`.** Holds the NTAPS-deep shift register with `shift`, `clear` and `din` inputs. The FSM and counters stay in `fir_tap_window`.

## Test plan
- **Reset then fill, DECIM = 1.** Feed 37 samples valued 1..37 back-to-back.
  - `t_valid` first high 1 cycle after the 37th accept, with `taps[0]` = 37 and `taps[36]` = 1.
  - Sample 38 gives `t_valid` again, with `taps[36]` = 2.
- **DECIM = 4, 49 samples.** `t_valid` fires after accepts 37, 41, 45 and 49 only (4 strobes).
- **Sign extension.** Feed `s_data` = 14'h2000 (−8192) → the `taps[0]` entry is 15'h6000 (−8192).
- **Flush in RUN.** After 40 samples, pulse `flush`.
  - `s_ready` is 0 for 37 cycles; 37 `t_valid` strobes occur (DECIM = 1).
  - Final window is all zeros; state ends in IDLE with `busy` 0.
- **Flush in FILL, with a simultaneous sample.** After 10 samples, assert `flush` together with `s_valid`.
  - The sample is not accepted; all taps are 0 the next cycle.
  - No `t_valid` occurs; the following 37 samples are needed for the first strobe.
- **EN and reset interplay.**
  - Drop `EN` for 5 cycles mid-FLUSH → the flush completes 5 cycles later than with `EN` held high.
  - Assert `RST_N` = 0 mid-RUN → the next cycle shows all outputs at their reset values.
